// File: rtl/calc_sequencer_if.sv
// Host/calculator bus for calc_sequencer.
//   master : sequencer side (takes host controls and calculator busY/Carry,
//            drives calculator controls and host status)
//   slave  : host/calculator side (the mirror image)
// Host controls : Start, Stop, LdEn, LdAddr, LdData
// Calculator in : busY, Carry
// Calculator out: WEN, RW, RX, RY, DataIn, Sel, Ctrl
// Host status   : Busy, Done, Result, ResultValid, CarryFlag
interface calc_sequencer_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned IW = 24
);
    logic          Start;
    logic          Stop;
    logic          LdEn;
    logic [AW-1:0] LdAddr;
    logic [IW-1:0] LdData;
    logic [7:0]    busY;
    logic          Carry;
    logic          WEN;
    logic [2:0]    RW;
    logic [2:0]    RX;
    logic [2:0]    RY;
    logic [7:0]    DataIn;
    logic          Sel;
    logic [3:0]    Ctrl;
    logic          Busy;
    logic          Done;
    logic [7:0]    Result;
    logic          ResultValid;
    logic          CarryFlag;

    modport master (
        input  Start, Stop, LdEn, LdAddr, LdData, busY, Carry,
        output WEN, RW, RX, RY, DataIn, Sel, Ctrl,
        output Busy, Done, Result, ResultValid, CarryFlag
    );

    modport slave (
        output Start, Stop, LdEn, LdAddr, LdData, busY, Carry,
        input  WEN, RW, RX, RY, DataIn, Sel, Ctrl,
        input  Busy, Done, Result, ResultValid, CarryFlag
    );
endinterface

// File: rtl/calc_sequencer.sv
// Program-driven initiator for the 8-bit simple calculator.
// Ports:
//   Clk  - rising-edge clock
//   Rst  - asynchronous active-high reset
//   bus  - calc_sequencer_if.master: program load, Start/Stop, calculator
//          drive (WEN/RW/RX/RY/DataIn/Sel/Ctrl), calculator sample
//          (busY/Carry) and status (Busy/Done/Result/ResultValid/CarryFlag)
// Each instruction takes a FETCH cycle and an ISSUE cycle. The calculator
// drive fields are registered at the FETCH->ISSUE edge and cleared at the
// next edge, so they are non-zero exactly during ISSUE and clear
// asynchronously on reset.
module calc_sequencer #(
    parameter int unsigned AW = 4,
    parameter int unsigned IW = 24
) (
    input  logic             Clk,
    input  logic             Rst,
    calc_sequencer_if.master bus
);
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [1:0] OP_EXEC = 2'b00;
    localparam logic [1:0] OP_PEEK = 2'b01;
    localparam logic [1:0] OP_BRC  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] ctrl;
        logic       sel;
        logic [2:0] rw;
        logic [2:0] rx;
        logic [2:0] ry;
        logic [7:0] imm;
    } instr_t;

    // Non-op part of the instruction register; doubles as the calculator drive.
    typedef struct packed {
        logic [3:0] ctrl;
        logic       sel;
        logic [2:0] rw;
        logic [2:0] rx;
        logic [2:0] ry;
        logic [7:0] imm;
    } drive_t;

    logic [IW-1:0] mem [DEPTH];

    state_t        state, state_n;
    logic [AW-1:0] pc, pc_n;
    logic [1:0]    op_q, op_n;
    drive_t        drv_q, drv_n;
    logic          wen_q, wen_n;
    logic [7:0]    result_q, result_n;
    logic          rvalid_q, rvalid_n;
    logic          cflag_q, cflag_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic          mem_we;
    instr_t        fetched;

    // Program memory: no reset, contents survive Rst.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[bus.LdAddr] <= bus.LdData;
        end
    end

    // State and output registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            op_q     <= '0;
            drv_q    <= '0;
            wen_q    <= 1'b0;
            result_q <= '0;
            rvalid_q <= 1'b0;
            cflag_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            op_q     <= op_n;
            drv_q    <= drv_n;
            wen_q    <= wen_n;
            result_q <= result_n;
            rvalid_q <= rvalid_n;
            cflag_q  <= cflag_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        op_n     = op_q;
        drv_n    = '0;
        wen_n    = 1'b0;
        result_n = result_q;
        rvalid_n = 1'b0;
        cflag_n  = cflag_q;
        mem_we   = 1'b0;
        fetched  = instr_t'(mem[pc]);

        case (state)
            S_IDLE: begin
                // A load in the same cycle as Start wins; Start is dropped.
                if (bus.LdEn) begin
                    mem_we = 1'b1;
                end else if (bus.Start) begin
                    pc_n    = '0;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                op_n  = fetched.op;
                drv_n = '{ctrl: fetched.ctrl, sel: fetched.sel, rw: fetched.rw,
                          rx: fetched.rx, ry: fetched.ry, imm: fetched.imm};
                wen_n = (fetched.op == OP_EXEC);
                state_n = S_ISSUE;
                if (bus.Stop) begin
                    drv_n   = '0;
                    wen_n   = 1'b0;
                    state_n = S_DONE;
                end
            end
            S_ISSUE: begin
                state_n = S_FETCH;
                case (op_q)
                    OP_EXEC: begin
                        cflag_n = bus.Carry;
                        pc_n    = pc + AW'(1);
                    end
                    OP_PEEK: begin
                        result_n = bus.busY;
                        rvalid_n = 1'b1;
                        pc_n     = pc + AW'(1);
                    end
                    OP_BRC: begin
                        // Uses the flag as it stood before this edge.
                        pc_n = cflag_q ? drv_q.imm[AW-1:0] : pc + AW'(1);
                    end
                    default: begin
                        state_n = S_DONE;
                    end
                endcase
                // Stop overrides the next state but not this cycle's effects.
                if (bus.Stop) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n == S_FETCH) || (state_n == S_ISSUE);
        done_n = (state_n == S_DONE);
    end

    assign bus.WEN         = wen_q;
    assign bus.RW          = drv_q.rw;
    assign bus.RX          = drv_q.rx;
    assign bus.RY          = drv_q.ry;
    assign bus.DataIn      = drv_q.imm;
    assign bus.Sel         = drv_q.sel;
    assign bus.Ctrl        = drv_q.ctrl;
    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.Result      = result_q;
    assign bus.ResultValid = rvalid_q;
    assign bus.CarryFlag   = cflag_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: reset state, a vector table of
// single-instruction programs, hand-written timing/branch/wrap/load/reset
// sequences, and random programs checked against an instruction-level model.
module tb_calc_sequencer;
    localparam int unsigned AW = 4;
    localparam int unsigned IW = 24;

    logic clk;
    logic rst;

    calc_sequencer_if #(.AW(AW), .IW(IW)) bus ();

    calc_sequencer #(.AW(AW), .IW(IW)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instruction-level model state.
    logic [23:0] prog [16];
    logic        m_cf;
    logic [7:0]  m_res;

    typedef struct {
        logic [23:0] word;
        logic        carry;
        logic [7:0]  by;
        logic        wen;
        logic [2:0]  rw;
        logic [2:0]  rx;
        logic [2:0]  ry;
        logic        sel;
        logic [3:0]  ctrl;
        logic [7:0]  din;
        logic        rv;
        logic [7:0]  res;
        logic        cf;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] enc(input logic [1:0] op, input logic [3:0] ctrl,
                                        input logic sel, input logic [2:0] rw,
                                        input logic [2:0] rx, input logic [2:0] ry,
                                        input logic [7:0] imm);
        return {op, ctrl, sel, rw, rx, ry, imm};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_cf  = 1'b0;
        m_res = 8'h00;
        cyc();
    endtask

    task automatic load(input logic [3:0] a, input logic [23:0] w);
        bus.LdEn   = 1'b1;
        bus.LdAddr = a;
        bus.LdData = w;
        cyc();
        bus.LdEn = 1'b0;
        prog[a]  = w;
    endtask

    task automatic wait_done(input string name);
        logic got;
        got = 1'b0;
        for (int t = 0; t < 12; t++) begin
            if (bus.Done) begin
                got = 1'b1;
                break;
            end
            cyc();
        end
        chk(name, 32'(got), 32'd1);
        cyc();
    endtask

    // Run prog[] from address 0; Stop is raised in the ISSUE of instruction
    // number max_instr if no HALT came first. carry_mode: 0/1 fixed, 2 random.
    task automatic run_program(input int max_instr, input int carry_mode);
        logic [3:0]  mpc;
        logic [23:0] w;
        logic [1:0]  op;
        logic        exp_rv;
        logic        last;
        logic        c_in;
        logic [7:0]  y_in;
        bus.Start = 1'b1;
        cyc();
        bus.Start = 1'b0;
        chk("fetch_busy", 32'(bus.Busy), 32'd1);
        chk("fetch_wen", 32'(bus.WEN), 32'd0);
        mpc = 4'd0;
        for (int k = 0; k < max_instr; k++) begin
            c_in = (carry_mode == 2) ? 1'($urandom) : 1'(carry_mode);
            y_in = 8'($urandom);
            bus.Carry = c_in;
            bus.busY  = y_in;
            cyc();
            w  = prog[mpc];
            op = w[23:22];
            chk("issue_wen", 32'(bus.WEN), 32'(op == 2'b00));
            chk("issue_ctrl", 32'(bus.Ctrl), 32'(w[21:18]));
            chk("issue_sel", 32'(bus.Sel), 32'(w[17]));
            chk("issue_rw", 32'(bus.RW), 32'(w[16:14]));
            chk("issue_rx", 32'(bus.RX), 32'(w[13:11]));
            chk("issue_ry", 32'(bus.RY), 32'(w[10:8]));
            chk("issue_din", 32'(bus.DataIn), 32'(w[7:0]));
            chk("issue_busy", 32'(bus.Busy), 32'd1);
            exp_rv = 1'b0;
            last   = (op == 2'b11) || (k == max_instr - 1);
            if (op != 2'b11 && k == max_instr - 1) bus.Stop = 1'b1;
            case (op)
                2'b00: begin m_cf = c_in; mpc = mpc + 4'd1; end
                2'b01: begin m_res = y_in; exp_rv = 1'b1; mpc = mpc + 4'd1; end
                2'b10: mpc = m_cf ? w[3:0] : mpc + 4'd1;
                default: ;
            endcase
            cyc();
            bus.Stop = 1'b0;
            chk("res_valid", 32'(bus.ResultValid), 32'(exp_rv));
            chk("result", 32'(bus.Result), 32'(m_res));
            chk("carry_flag", 32'(bus.CarryFlag), 32'(m_cf));
            if (last) begin
                chk("done_pulse", 32'(bus.Done), 32'd1);
                chk("done_busy", 32'(bus.Busy), 32'd0);
                chk("done_wen", 32'(bus.WEN), 32'd0);
                cyc();
                chk("done_clear", 32'(bus.Done), 32'd0);
                chk("idle_busy", 32'(bus.Busy), 32'd0);
                break;
            end else begin
                chk("fetch_busy", 32'(bus.Busy), 32'd1);
                chk("fetch_wen", 32'(bus.WEN), 32'd0);
                chk("fetch_done", 32'(bus.Done), 32'd0);
            end
        end
    endtask

    initial begin
        logic exp_wen [6];
        logic exp_bsy [6];
        logic exp_dn  [6];
        logic [1:0] rop;

        rst = 1'b1;
        bus.Start = 1'b0; bus.Stop = 1'b0; bus.LdEn = 1'b0;
        bus.LdAddr = '0;  bus.LdData = '0;
        bus.busY = 8'h00; bus.Carry = 1'b0;
        m_cf = 1'b0; m_res = 8'h00;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen", 32'(bus.WEN), 32'd0);
        chk("rst_din", 32'(bus.DataIn), 32'd0);
        chk("rst_ctrl", 32'(bus.Ctrl), 32'd0);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_result", 32'(bus.Result), 32'd0);
        chk("rst_rv", 32'(bus.ResultValid), 32'd0);
        chk("rst_cf", 32'(bus.CarryFlag), 32'd0);
        rst = 1'b0;
        cyc();

        // Vector table: one instruction followed by HALT, run from reset.
        vecs[0] = '{enc(2'b00, 4'h3, 1'b0, 3'd1, 3'd2, 3'd3, 8'h05), 1'b1, 8'hAA,
                    1'b1, 3'd1, 3'd2, 3'd3, 1'b0, 4'h3, 8'h05, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{enc(2'b00, 4'hF, 1'b1, 3'd7, 3'd0, 3'd5, 8'hFF), 1'b0, 8'h11,
                    1'b1, 3'd7, 3'd0, 3'd5, 1'b1, 4'hF, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{enc(2'b01, 4'h0, 1'b0, 3'd0, 3'd0, 3'd3, 8'h00), 1'b1, 8'h3C,
                    1'b0, 3'd0, 3'd0, 3'd3, 1'b0, 4'h0, 8'h00, 1'b1, 8'h3C, 1'b0};
        vecs[3] = '{enc(2'b01, 4'hA, 1'b1, 3'd5, 3'd6, 3'd7, 8'h81), 1'b0, 8'hC3,
                    1'b0, 3'd5, 3'd6, 3'd7, 1'b1, 4'hA, 8'h81, 1'b1, 8'hC3, 1'b0};
        vecs[4] = '{enc(2'b10, 4'h1, 1'b0, 3'd0, 3'd0, 3'd0, 8'h09), 1'b1, 8'h00,
                    1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 4'h1, 8'h09, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{enc(2'b11, 4'h6, 1'b1, 3'd2, 3'd4, 3'd1, 8'h44), 1'b1, 8'h5A,
                    1'b0, 3'd2, 3'd4, 3'd1, 1'b1, 4'h6, 8'h44, 1'b0, 8'h00, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            load(4'd0, vecs[i].word);
            load(4'd1, enc(2'b11, 4'h0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00));
            bus.Carry = vecs[i].carry;
            bus.busY  = vecs[i].by;
            bus.Start = 1'b1;
            cyc();
            bus.Start = 1'b0;
            cyc();
            chk("tbl_wen", 32'(bus.WEN), 32'(vecs[i].wen));
            chk("tbl_rw", 32'(bus.RW), 32'(vecs[i].rw));
            chk("tbl_rx", 32'(bus.RX), 32'(vecs[i].rx));
            chk("tbl_ry", 32'(bus.RY), 32'(vecs[i].ry));
            chk("tbl_sel", 32'(bus.Sel), 32'(vecs[i].sel));
            chk("tbl_ctrl", 32'(bus.Ctrl), 32'(vecs[i].ctrl));
            chk("tbl_din", 32'(bus.DataIn), 32'(vecs[i].din));
            cyc();
            chk("tbl_rv", 32'(bus.ResultValid), 32'(vecs[i].rv));
            chk("tbl_res", 32'(bus.Result), 32'(vecs[i].res));
            chk("tbl_cf", 32'(bus.CarryFlag), 32'(vecs[i].cf));
            wait_done("tbl_done");
        end

        // Timing: EXEC then HALT; WEN at +2, Busy for 4 cycles, Done at +5.
        do_reset();
        load(4'd0, enc(2'b00, 4'h0, 1'b0, 3'd1, 3'd0, 3'd0, 8'h05));
        load(4'd1, enc(2'b11, 4'h0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00));
        exp_wen = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_bsy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_dn  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.Start = 1'b1;
        for (int j = 0; j < 6; j++) begin
            cyc();
            bus.Start = 1'b0;
            chk("tim_wen", 32'(bus.WEN), 32'(exp_wen[j]));
            chk("tim_busy", 32'(bus.Busy), 32'(exp_bsy[j]));
            chk("tim_done", 32'(bus.Done), 32'(exp_dn[j]));
            if (exp_wen[j]) begin
                chk("tim_rw", 32'(bus.RW), 32'd1);
                chk("tim_din", 32'(bus.DataIn), 32'h05);
            end
        end

        // Branch on carry, taken then not taken.
        load(4'd0, enc(2'b00, 4'h2, 1'b1, 3'd1, 3'd1, 3'd1, 8'h01));
        load(4'd1, enc(2'b10, 4'h0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h09));
        load(4'd2, enc(2'b00, 4'h1, 1'b0, 3'd2, 3'd0, 3'd0, 8'h22));
        load(4'd3, enc(2'b11, 4'h0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00));
        load(4'd9, enc(2'b00, 4'h1, 1'b0, 3'd6, 3'd0, 3'd0, 8'h99));
        load(4'd10, enc(2'b11, 4'h0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00));
        run_program(8, 1);
        run_program(8, 0);

        // Wrap: 16 EXECs, no HALT, Stop after 18 instructions.
        for (int a = 0; a < 16; a++)
            load(4'(a), enc(2'b00, 4'(a), 1'(a), 3'(a), 3'(a + 1), 3'(a + 2), 8'(a + 8'h10)));
        run_program(18, 2);

        // Load and Start while busy are ignored.
        load(4'd0, enc(2'b00, 4'h4, 1'b0, 3'd1, 3'd2, 3'd3, 8'h11));
        load(4'd1, enc(2'b00, 4'h5, 1'b1, 3'd2, 3'd3, 3'd4, 8'h22));
        load(4'd2, enc(2'b11, 4'h0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00));
        bus.Start = 1'b1;
        cyc();
        bus.LdEn = 1'b1;
        bus.LdAddr = 4'd0;
        bus.LdData = enc(2'b11, 4'hE, 1'b1, 3'd7, 3'd7, 3'd7, 8'hEE);
        cyc();
        bus.LdEn = 1'b0;
        bus.Start = 1'b0;
        wait_done("busy_ld_done");
        for (int j = 0; j < 3; j++) begin
            chk("no_restart", 32'(bus.Busy), 32'd0);
            cyc();
        end
        run_program(8, 2);

        // LdEn with Start in IDLE: word written, no start.
        bus.LdEn = 1'b1;
        bus.Start = 1'b1;
        bus.LdAddr = 4'd1;
        bus.LdData = enc(2'b01, 4'h0, 1'b0, 3'd0, 3'd0, 3'd3, 8'h00);
        cyc();
        bus.LdEn = 1'b0;
        bus.Start = 1'b0;
        prog[1] = enc(2'b01, 4'h0, 1'b0, 3'd0, 3'd0, 3'd3, 8'h00);
        chk("ld_start_idle0", 32'(bus.Busy), 32'd0);
        cyc();
        chk("ld_start_idle1", 32'(bus.Busy), 32'd0);
        run_program(8, 2);

        // Reset in the middle of an EXEC issue.
        bus.Start = 1'b1;
        cyc();
        bus.Start = 1'b0;
        cyc();
        chk("pre_rst_wen", 32'(bus.WEN), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wen", 32'(bus.WEN), 32'd0);
        chk("arst_rw", 32'(bus.RW), 32'd0);
        chk("arst_din", 32'(bus.DataIn), 32'd0);
        chk("arst_ctrl", 32'(bus.Ctrl), 32'd0);
        chk("arst_busy", 32'(bus.Busy), 32'd0);
        chk("arst_cf", 32'(bus.CarryFlag), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_cf = 1'b0;
        m_res = 8'h00;
        cyc();
        run_program(8, 2);

        // Random programs against the model.
        for (int p = 0; p < 6; p++) begin
            for (int a = 0; a < 16; a++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: rop = 2'b00;
                    5, 6:          rop = 2'b01;
                    7, 8:          rop = 2'b10;
                    default:       rop = 2'b11;
                endcase
                load(4'(a), {rop, 22'($urandom)});
            end
            run_program(24, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
